mem_stage_lsu: RTL and testbench

//  Parametrised MEM pipeline stage with a variable-latency data-memory read port.
//  - Sits between the EX/MEM pipeline register input and the WB stage.
//  - Aligns and sign/zero-extends load data for any bus width; holds the stage via stallreq_mem until data returns.
//  - Buffers early responses, times out lost responses, and drives the same bypass data to the register-file forward path.

---
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with a variable-latency data-memory read port.
// Aligns and extends load data, stalls until the response returns, and times out lost responses.
module mem_stage_lsu #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RF_AW    = 5,
    parameter int unsigned HILO_W   = 66,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [5:0]                    stall,
    input  logic                          ex_valid,
    input  logic [31:0]                   ex_pc,
    input  logic [4:0]                    ex_load_op,
    input  logic [$clog2(DATA_W/8)-1:0]   ex_addr_lo,
    input  logic                          ex_rf_we,
    input  logic [RF_AW-1:0]              ex_rf_waddr,
    input  logic [31:0]                   ex_result,
    input  logic [HILO_W-1:0]             ex_hilo,
    input  logic                          dmem_rvalid,
    input  logic [DATA_W-1:0]             dmem_rdata,
    output logic                          stallreq_mem,
    output logic                          wb_valid,
    output logic [31:0]                   wb_pc,
    output logic                          wb_rf_we,
    output logic [RF_AW-1:0]              wb_rf_waddr,
    output logic [31:0]                   wb_rf_wdata,
    output logic [HILO_W-1:0]             wb_hilo,
    output logic                          fwd_rf_we,
    output logic [RF_AW-1:0]              fwd_rf_waddr,
    output logic [31:0]                   fwd_rf_wdata,
    output logic                          timeout_err
);

    localparam int unsigned AW = $clog2(DATA_W / 8);

    localparam logic [4:0] OpLb  = 5'b10000;
    localparam logic [4:0] OpLbu = 5'b01000;
    localparam logic [4:0] OpLh  = 5'b00100;
    localparam logic [4:0] OpLhu = 5'b00010;
    localparam logic [4:0] OpLw  = 5'b00001;

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              timeout_q;

    logic              valid_q;
    logic [31:0]       pc_q;
    logic [4:0]        load_op_q;
    logic [AW-1:0]     addr_lo_q;
    logic              rf_we_q;
    logic [RF_AW-1:0]  rf_waddr_q;
    logic [31:0]       result_q;
    logic [HILO_W-1:0] hilo_q;

    logic capture, bubble, ex_is_load, is_load_q, timeout_hit, resolved;
    logic unused_stall;

    assign capture     = ~stall[3];
    assign bubble      = stall[3] & ~stall[4];
    assign ex_is_load  = ex_valid & (|ex_load_op);
    assign is_load_q   = valid_q & (|load_op_q);
    // A response in the same cycle as the limit still wins over the timeout.
    assign timeout_hit = (state_q == StWait) & ~dmem_rvalid & (wait_cnt_q == 8'(MAX_WAIT));
    assign resolved    = (state_q != StWait) | dmem_rvalid | timeout_hit;
    assign unused_stall = ^{stall[5], stall[2:0]};

    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            load_op_q  <= '0;
            addr_lo_q  <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            result_q   <= '0;
            hilo_q     <= '0;
        end else if (capture) begin
            valid_q    <= ex_valid;
            pc_q       <= ex_pc;
            load_op_q  <= ex_load_op;
            addr_lo_q  <= ex_addr_lo;
            rf_we_q    <= ex_rf_we;
            rf_waddr_q <= ex_rf_waddr;
            result_q   <= ex_result;
            hilo_q     <= ex_hilo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            rbuf_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rbuf_q     <= rbuf_d;
            timeout_q  <= timeout_q | timeout_hit;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rbuf_d     = rbuf_q;
        if (state_q == StWait) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
            if (dmem_rvalid) begin
                state_d = StDone;
                rbuf_d  = dmem_rdata;
            end else if (timeout_hit) begin
                state_d = StDone;
                rbuf_d  = '0;
            end
        end
        if (bubble) begin
            state_d    = StIdle;
            wait_cnt_d = '0;
        end else if (capture) begin
            wait_cnt_d = '0;
            if (!ex_is_load) begin
                state_d = StIdle;
            end else if (dmem_rvalid && state_q != StWait) begin
                // Early response: data arrives with the load itself.
                state_d = StDone;
                rbuf_d  = dmem_rdata;
            end else begin
                // In WAIT, a coincident rvalid belongs to the load leaving the stage.
                state_d = StWait;
            end
        end
    end

    logic [DATA_W-1:0] raw;
    logic [AW-1:0]     half_off, word_off;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       word_lane;
    logic [31:0]       load_data;

    always_comb begin
        raw = rbuf_q;
        if (state_q == StWait) begin
            raw = dmem_rvalid ? dmem_rdata : '0;
        end
        half_off  = addr_lo_q & ~AW'(1);
        word_off  = addr_lo_q & ~AW'(3);
        byte_lane = 8'(raw >> {addr_lo_q, 3'b000});
        half_lane = 16'(raw >> {half_off, 3'b000});
        word_lane = 32'(raw >> {word_off, 3'b000});
        load_data = '0;
        unique case (load_op_q)
            OpLb:    load_data = {{24{byte_lane[7]}}, byte_lane};
            OpLbu:   load_data = {24'd0, byte_lane};
            OpLh:    load_data = {{16{half_lane[15]}}, half_lane};
            OpLhu:   load_data = {16'd0, half_lane};
            OpLw:    load_data = word_lane;
            default: load_data = '0;
        endcase
    end

    always_comb begin
        stallreq_mem = (state_q == StWait) & ~dmem_rvalid & ~timeout_hit;
        wb_valid     = valid_q & resolved;
        wb_pc        = pc_q;
        wb_rf_we     = valid_q & rf_we_q & resolved;
        wb_rf_waddr  = rf_waddr_q;
        wb_rf_wdata  = is_load_q ? load_data : result_q;
        wb_hilo      = hilo_q;
        fwd_rf_we    = wb_rf_we;
        fwd_rf_waddr = wb_rf_waddr;
        fwd_rf_wdata = wb_rf_wdata;
        timeout_err  = timeout_q | timeout_hit;
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: 32-bit and 64-bit instances, scoreboard of
// expected write-back results popped when the stage presents a completed instruction.
module tb_mem_stage_lsu;

    localparam logic [4:0] OP_LB  = 5'h10;
    localparam logic [4:0] OP_LW  = 5'h01;
    localparam logic [5:0] HOLD   = 6'b011111;
    localparam logic [5:0] BUBBLE = 6'b001111;

    // {op[4:0], addr_lo[2:0], expected[31:0]} against rdata 0x8A7F_C301
    localparam logic [39:0] LANE32 [10] = '{
        {5'h10, 3'd0, 32'h0000_0001}, {5'h10, 3'd1, 32'hFFFF_FFC3},
        {5'h08, 3'd1, 32'h0000_00C3}, {5'h10, 3'd3, 32'hFFFF_FF8A},
        {5'h08, 3'd2, 32'h0000_007F}, {5'h04, 3'd0, 32'hFFFF_C301},
        {5'h02, 3'd0, 32'h0000_C301}, {5'h04, 3'd3, 32'hFFFF_8A7F},
        {5'h02, 3'd2, 32'h0000_8A7F}, {5'h01, 3'd1, 32'h8A7F_C301}
    };
    // {op, addr_lo, expected, rdata[63:0]}
    localparam logic [103:0] LANE64 [6] = '{
        {5'h02, 3'd6, 32'h0000_BEEF, 64'hBEEF_0000_0000_0000},
        {5'h01, 3'd4, 32'h89AB_CDEF, 64'h89AB_CDEF_0123_4567},
        {5'h10, 3'd7, 32'hFFFF_FF89, 64'h89AB_CDEF_0123_4567},
        {5'h02, 3'd2, 32'h0000_0123, 64'h89AB_CDEF_0123_4567},
        {5'h08, 3'd5, 32'h0000_00CD, 64'h89AB_CDEF_0123_4567},
        {5'h04, 3'd4, 32'hFFFF_CDEF, 64'h89AB_CDEF_0123_4567}
    };

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [5:0]  stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_load_op;
    logic [2:0]  ex_addr_lo;
    logic        ex_rf_we;
    logic [4:0]  ex_rf_waddr;
    logic [31:0] ex_result;
    logic [65:0] ex_hilo;
    logic        dmem_rvalid;
    logic [31:0] rdata32;
    logic [63:0] rdata64;

    logic        a_stallreq, a_wb_valid, a_wb_rf_we, a_fwd_rf_we, a_timeout;
    logic [31:0] a_wb_pc, a_wb_rf_wdata, a_fwd_rf_wdata;
    logic [4:0]  a_wb_rf_waddr, a_fwd_rf_waddr;
    logic [65:0] a_wb_hilo;
    logic        b_stallreq, b_wb_valid, b_wb_rf_we, b_fwd_rf_we, b_timeout;
    logic [31:0] b_wb_pc, b_wb_rf_wdata, b_fwd_rf_wdata;
    logic [4:0]  b_wb_rf_waddr, b_fwd_rf_waddr;
    logic [65:0] b_wb_hilo;

    mem_stage_lsu #(.DATA_W(32)) dut32 (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_load_op(ex_load_op), .ex_addr_lo(ex_addr_lo[1:0]), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result), .ex_hilo(ex_hilo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(rdata32), .stallreq_mem(a_stallreq),
        .wb_valid(a_wb_valid), .wb_pc(a_wb_pc), .wb_rf_we(a_wb_rf_we),
        .wb_rf_waddr(a_wb_rf_waddr), .wb_rf_wdata(a_wb_rf_wdata), .wb_hilo(a_wb_hilo),
        .fwd_rf_we(a_fwd_rf_we), .fwd_rf_waddr(a_fwd_rf_waddr),
        .fwd_rf_wdata(a_fwd_rf_wdata), .timeout_err(a_timeout)
    );

    mem_stage_lsu #(.DATA_W(64)) dut64 (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_load_op(ex_load_op), .ex_addr_lo(ex_addr_lo), .ex_rf_we(ex_rf_we),
        .ex_rf_waddr(ex_rf_waddr), .ex_result(ex_result), .ex_hilo(ex_hilo),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(rdata64), .stallreq_mem(b_stallreq),
        .wb_valid(b_wb_valid), .wb_pc(b_wb_pc), .wb_rf_we(b_wb_rf_we),
        .wb_rf_waddr(b_wb_rf_waddr), .wb_rf_wdata(b_wb_rf_wdata), .wb_hilo(b_wb_hilo),
        .fwd_rf_we(b_fwd_rf_we), .fwd_rf_waddr(b_fwd_rf_waddr),
        .fwd_rf_wdata(b_fwd_rf_wdata), .timeout_err(b_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 6'd0; ex_valid = 1'b0; ex_pc = '0; ex_load_op = '0; ex_addr_lo = '0;
        ex_rf_we = 1'b0; ex_rf_waddr = '0; ex_result = '0; ex_hilo = '0;
        dmem_rvalid = 1'b0; rdata32 = '0; rdata64 = '0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] op, input logic [2:0] lo,
                         input logic [4:0] waddr, input logic [31:0] res);
        ex_valid = 1'b1; ex_pc = pc; ex_load_op = op; ex_addr_lo = lo;
        ex_rf_we = 1'b1; ex_rf_waddr = waddr; ex_result = res;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        ex_valid = 1'b1; ex_rf_we = 1'b1; ex_result = 32'hFFFF_FFFF;
        step();
        step();
        @(negedge clk);
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", a_wb_valid); end
        checks++; if (a_stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b want 0", a_stallreq); end
        checks++; if (a_wb_rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", a_wb_rf_wdata); end
        checks++; if (a_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", a_timeout); end
        checks++; if (b_wb_rf_we !== 1'b0) begin errors++; $display("FAIL reset_we64: got %b want 0", b_wb_rf_we); end
        step();
        rst = 1'b0;
        idle_inputs();
    endtask

    task automatic test_nonload();
        exp_t e;
        issue(32'h0000_0100, 5'd0, 3'd0, 5'd3, 32'h1234_5678);
        ex_hilo = 66'h3_0123_4567_89AB_CDEF;
        sb.push_back('{pc: 32'h0000_0100, waddr: 5'd3, wdata: 32'h1234_5678});
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (a_wb_valid !== 1'b1) begin errors++; $display("FAIL nonload_valid: got %b want 1", a_wb_valid); end
        e = sb.pop_front();
        checks++; if (a_wb_rf_wdata !== e.wdata) begin errors++; $display("FAIL nonload_wdata: got %h want %h", a_wb_rf_wdata, e.wdata); end
        checks++; if (a_wb_rf_we !== 1'b1 || a_wb_rf_waddr !== e.waddr || a_wb_pc !== e.pc) begin
            errors++; $display("FAIL nonload_ctrl: got we=%b wa=%0d pc=%h want 1 %0d %h", a_wb_rf_we, a_wb_rf_waddr, a_wb_pc, e.waddr, e.pc);
        end
        checks++; if (a_stallreq !== 1'b0) begin errors++; $display("FAIL nonload_stallreq: got %b want 0", a_stallreq); end
        checks++; if (a_fwd_rf_we !== 1'b1 || a_fwd_rf_waddr !== 5'd3 || a_fwd_rf_wdata !== 32'h1234_5678) begin
            errors++; $display("FAIL nonload_fwd: got %b %0d %h want 1 3 12345678", a_fwd_rf_we, a_fwd_rf_waddr, a_fwd_rf_wdata);
        end
        checks++; if (a_wb_hilo !== 66'h3_0123_4567_89AB_CDEF) begin errors++; $display("FAIL nonload_hilo: got %h want 30123456789abcdef", a_wb_hilo); end
        step();
    endtask

    task automatic test_load_stall();
        exp_t e;
        idle_inputs();
        issue(32'h0000_0200, OP_LB, 3'd2, 5'd5, 32'hDEAD_0000);
        sb.push_back('{pc: 32'h0000_0200, waddr: 5'd5, wdata: 32'hFFFF_FF80});
        step();
        idle_inputs();
        stall = HOLD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (a_stallreq !== 1'b1) begin errors++; $display("FAIL wait_stallreq[%0d]: got %b want 1", i, a_stallreq); end
            checks++; if (a_wb_rf_we !== 1'b0) begin errors++; $display("FAIL wait_we[%0d]: got %b want 0", i, a_wb_rf_we); end
            step();
        end
        dmem_rvalid = 1'b1;
        rdata32 = 32'h0080_0000;
        @(negedge clk);
        checks++; if (a_stallreq !== 1'b0) begin errors++; $display("FAIL rvalid_stallreq: got %b want 0", a_stallreq); end
        checks++; if (a_wb_valid !== 1'b1) begin errors++; $display("FAIL rvalid_valid: got %b want 1", a_wb_valid); end
        e = sb.pop_front();
        checks++; if (a_wb_rf_wdata !== e.wdata || a_wb_rf_we !== 1'b1) begin
            errors++; $display("FAIL lb_wdata: got %h we=%b want %h we=1", a_wb_rf_wdata, a_wb_rf_we, e.wdata);
        end
        checks++; if (a_wb_rf_waddr !== e.waddr || a_wb_pc !== e.pc) begin
            errors++; $display("FAIL lb_ctrl: got %0d %h want %0d %h", a_wb_rf_waddr, a_wb_pc, e.waddr, e.pc);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (a_wb_rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_done_wdata: got %h want ffffff80", a_wb_rf_wdata); end
        step();
    endtask

    task automatic test_lanes32();
        exp_t e;
        logic [39:0] ent;
        for (int i = 0; i < 10; i++) begin
            ent = LANE32[i];
            idle_inputs();
            issue(32'h300 + 32'(i * 4), ent[39:35], ent[34:32], 5'(i + 1), 32'h0);
            sb.push_back('{pc: 32'h300 + 32'(i * 4), waddr: 5'(i + 1), wdata: ent[31:0]});
            step();
            idle_inputs();
            dmem_rvalid = 1'b1;
            rdata32 = 32'h8A7F_C301;
            @(negedge clk);
            checks++; if (a_wb_valid !== 1'b1 || a_wb_rf_we !== 1'b1) begin
                errors++; $display("FAIL lane32_we[%0d]: got %b %b want 1 1", i, a_wb_valid, a_wb_rf_we);
            end
            e = sb.pop_front();
            checks++; if (a_wb_rf_wdata !== e.wdata) begin errors++; $display("FAIL lane32[%0d]: got %h want %h", i, a_wb_rf_wdata, e.wdata); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_lanes64();
        exp_t e;
        logic [103:0] ent;
        for (int i = 0; i < 6; i++) begin
            ent = LANE64[i];
            idle_inputs();
            issue(32'h380 + 32'(i * 4), ent[103:99], ent[98:96], 5'(i + 11), 32'h0);
            sb.push_back('{pc: 32'h380 + 32'(i * 4), waddr: 5'(i + 11), wdata: ent[95:64]});
            step();
            idle_inputs();
            dmem_rvalid = 1'b1;
            rdata64 = ent[63:0];
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (b_wb_rf_wdata !== e.wdata || b_wb_rf_we !== 1'b1) begin
                errors++; $display("FAIL lane64[%0d]: got %h we=%b want %h we=1", i, b_wb_rf_wdata, b_wb_rf_we, e.wdata);
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_early_hold();
        exp_t e;
        idle_inputs();
        issue(32'h0000_0400, OP_LW, 3'd0, 5'd7, 32'h0);
        dmem_rvalid = 1'b1;
        rdata32 = 32'hCAFE_F00D;
        sb.push_back('{pc: 32'h0000_0400, waddr: 5'd7, wdata: 32'hCAFE_F00D});
        step();
        idle_inputs();
        stall = HOLD;
        rdata32 = 32'h0BAD_BEEF;
        @(negedge clk);
        checks++; if (a_stallreq !== 1'b0 || a_wb_valid !== 1'b1) begin
            errors++; $display("FAIL early_ctrl: got stallreq=%b valid=%b want 0 1", a_stallreq, a_wb_valid);
        end
        e = sb.pop_front();
        checks++; if (a_wb_rf_wdata !== e.wdata) begin errors++; $display("FAIL early_wdata: got %h want %h", a_wb_rf_wdata, e.wdata); end
        for (int i = 0; i < 2; i++) begin
            step();
            if (i == 1) dmem_rvalid = 1'b1;
            @(negedge clk);
            checks++; if (a_wb_rf_wdata !== e.wdata || a_fwd_rf_wdata !== e.wdata || a_wb_rf_we !== 1'b1) begin
                errors++; $display("FAIL early_hold[%0d]: got %h fwd=%h we=%b want %h", i, a_wb_rf_wdata, a_fwd_rf_wdata, a_wb_rf_we, e.wdata);
            end
        end
        idle_inputs();
        step();
        @(negedge clk);
        checks++; if (a_wb_valid !== 1'b0) begin errors++; $display("FAIL early_release: got valid=%b want 0", a_wb_valid); end
    endtask

    task automatic test_timeout();
        exp_t e;
        int n;
        idle_inputs();
        issue(32'h0000_0500, OP_LW, 3'd0, 5'd9, 32'h5555_5555);
        sb.push_back('{pc: 32'h0000_0500, waddr: 5'd9, wdata: 32'h0});
        step();
        idle_inputs();
        stall = HOLD;
        n = 0;
        @(negedge clk);
        while (a_stallreq === 1'b1 && n < 40) begin
            n++;
            step();
            @(negedge clk);
        end
        checks++; if (n != 15) begin errors++; $display("FAIL timeout_cycles: got %0d want 15", n); end
        checks++; if (a_timeout !== 1'b1 || a_stallreq !== 1'b0) begin
            errors++; $display("FAIL timeout_flag: got err=%b stallreq=%b want 1 0", a_timeout, a_stallreq);
        end
        e = sb.pop_front();
        checks++; if (a_wb_rf_wdata !== e.wdata || a_wb_rf_we !== 1'b1 || a_wb_rf_waddr !== e.waddr) begin
            errors++; $display("FAIL timeout_wdata: got %h we=%b wa=%0d want %h 1 %0d", a_wb_rf_wdata, a_wb_rf_we, a_wb_rf_waddr, e.wdata, e.waddr);
        end
        step();
        dmem_rvalid = 1'b1;
        rdata32 = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (a_wb_rf_wdata !== 32'd0) begin errors++; $display("FAIL late_in_done: got %h want 0", a_wb_rf_wdata); end
        idle_inputs();
        step();
        dmem_rvalid = 1'b1;
        rdata32 = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++; if (a_wb_valid !== 1'b0 || a_stallreq !== 1'b0 || a_wb_rf_wdata !== 32'd0) begin
            errors++; $display("FAIL late_in_idle: got valid=%b stallreq=%b wdata=%h want 0 0 0", a_wb_valid, a_stallreq, a_wb_rf_wdata);
        end
        checks++; if (a_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b want 1", a_timeout); end
        idle_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            issue(32'h600 + 32'(i * 4), 5'd0, 3'd0, 5'(10 + i), 32'hA000_0000 + 32'(i));
            sb.push_back('{pc: 32'h600 + 32'(i * 4), waddr: 5'(10 + i), wdata: 32'hA000_0000 + 32'(i)});
            step();
            @(negedge clk);
            e = sb.pop_front();
            checks++; if (a_wb_rf_wdata !== e.wdata || a_wb_rf_waddr !== e.waddr || a_wb_pc !== e.pc) begin
                errors++; $display("FAIL b2b[%0d]: got %h %0d %h want %h %0d %h", i, a_wb_rf_wdata, a_wb_rf_waddr, a_wb_pc, e.wdata, e.waddr, e.pc);
            end
        end
        issue(32'h0000_0700, OP_LW, 3'd0, 5'd20, 32'h0);
        sb.push_back('{pc: 32'h0000_0700, waddr: 5'd20, wdata: 32'h1111_2222});
        step();
        issue(32'h0000_0704, 5'd0, 3'd0, 5'd21, 32'h3333_4444);
        sb.push_back('{pc: 32'h0000_0704, waddr: 5'd21, wdata: 32'h3333_4444});
        dmem_rvalid = 1'b1;
        rdata32 = 32'h1111_2222;
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (a_wb_rf_wdata !== e.wdata || a_wb_rf_waddr !== e.waddr) begin
            errors++; $display("FAIL b2b_load: got %h %0d want %h %0d", a_wb_rf_wdata, a_wb_rf_waddr, e.wdata, e.waddr);
        end
        step();
        idle_inputs();
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (a_wb_rf_wdata !== e.wdata || a_wb_rf_waddr !== e.waddr || a_stallreq !== 1'b0) begin
            errors++; $display("FAIL b2b_after_load: got %h %0d stallreq=%b want %h %0d 0", a_wb_rf_wdata, a_wb_rf_waddr, a_stallreq, e.wdata, e.waddr);
        end
        step();
    endtask

    task automatic test_bubble();
        idle_inputs();
        issue(32'h0000_0800, OP_LW, 3'd0, 5'd22, 32'h0);
        step();
        idle_inputs();
        stall = BUBBLE;
        step();
        idle_inputs();
        @(negedge clk);
        checks++; if (a_wb_valid !== 1'b0 || a_stallreq !== 1'b0 || a_wb_rf_waddr !== 5'd0) begin
            errors++; $display("FAIL bubble: got valid=%b stallreq=%b wa=%0d want 0 0 0", a_wb_valid, a_stallreq, a_wb_rf_waddr);
        end
        step();
    endtask

    task automatic test_rst_mid_wait();
        idle_inputs();
        issue(32'h0000_0900, OP_LW, 3'd0, 5'd23, 32'h7777_7777);
        step();
        idle_inputs();
        stall = HOLD;
        step();
        @(negedge clk);
        checks++; if (a_stallreq !== 1'b1) begin errors++; $display("FAIL rst_pre_wait: got %b want 1", a_stallreq); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_stallreq !== 1'b0 || a_wb_valid !== 1'b0 || a_wb_rf_we !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl: got %b %b %b want 0 0 0", a_stallreq, a_wb_valid, a_wb_rf_we);
        end
        checks++; if (a_wb_rf_wdata !== 32'd0 || a_wb_pc !== 32'd0 || a_wb_rf_waddr !== 5'd0) begin
            errors++; $display("FAIL rst_mid_data: got %h %h %0d want 0 0 0", a_wb_rf_wdata, a_wb_pc, a_wb_rf_waddr);
        end
        checks++; if (a_timeout !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout: got %b want 0", a_timeout); end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_nonload();
        test_load_stall();
        test_lanes32();
        test_lanes64();
        test_early_hold();
        test_timeout();
        test_back_to_back();
        test_bubble();
        test_rst_mid_wait();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
